// File: rtl/sp_fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================
// sp_fifo_ctrl_pkg : shared buffer constants and access types
// Rev 1.0
// ============================================================
package sp_fifo_ctrl_pkg;

    localparam int c_DATA_W     = 16;
    localparam int c_ADDR_W     = 10;
    localparam int c_DEPTH      = 1 << c_ADDR_W;
    localparam int c_OBUF_DEPTH = 2;

    typedef enum logic [1:0] {
        ACC_IDLE = 2'd0,
        ACC_WR   = 2'd1,
        ACC_RD   = 2'd2
    } ram_acc_e;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_fifo_obuf.sv
`default_nettype none
// ============================================================
// sp_fifo_obuf : 2-entry register FIFO holding words read from RAM
// Rev 1.0
// ============================================================
module sp_fifo_obuf
    import sp_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = c_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_q [c_OBUF_DEPTH];
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              w_push, w_pop;

    assign w_pop  = out_valid && out_ready;
    assign w_push = in_valid && ((cnt_q != 2'd2) || w_pop);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (w_push) tail_d = ~tail_q;
        if (w_pop)  head_d = ~head_q;
        cnt_d = cnt_q + {1'b0, w_push} - {1'b0, w_pop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (w_push) mem_q[tail_q] <= in_data;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = out_valid ? mem_q[head_q] : '0;
    assign count     = cnt_q;

endmodule
`default_nettype wire

// File: rtl/sp_fifo_ctrl.sv
`default_nettype none
// ============================================================
// sp_fifo_ctrl : streaming FIFO controller over a single-port RAM
// Rev 1.0
// ============================================================
module sp_fifo_ctrl
    import sp_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_wre,
    output logic              ram_reset,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [ADDR_W:0] c_RAM_FULL = (ADDR_W+1)'(depth_of(ADDR_W));

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              inflight_q, inflight_d;
    logic              prio_rd_q, prio_rd_d;

    logic [1:0]        w_obuf_cnt, w_occ;
    logic              w_pop, w_ram_room, w_rd_req, w_wr_req, w_wr_gnt;
    ram_acc_e          w_acc;

    // A word leaving the output stage this cycle frees its slot for a new read,
    // which is what lets a lone reader drain one word per cycle.
    assign w_pop      = out_valid && out_ready;
    assign w_occ      = w_obuf_cnt + {1'b0, inflight_q} - {1'b0, w_pop};
    assign w_ram_room = (ram_cnt_q != c_RAM_FULL);
    assign w_rd_req   = !reset && (ram_cnt_q != '0) && (w_occ < 2'd2);
    assign w_wr_req   = !reset && in_valid && w_ram_room;
    assign in_ready   = !reset && w_ram_room && !(w_rd_req && prio_rd_q);
    assign w_wr_gnt   = in_valid && in_ready;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        ram_ce    = 1'b0;
        ram_wre   = 1'b0;
        ram_ad    = '0;
        ram_din   = '0;
        w_acc     = ACC_IDLE;
        if (w_wr_gnt)      w_acc = ACC_WR;
        else if (w_rd_req) w_acc = ACC_RD;
        case (w_acc)
            ACC_WR: begin
                ram_ce    = 1'b1;
                ram_wre   = 1'b1;
                ram_ad    = wr_ptr_q;
                ram_din   = in_data;
                wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
                ram_cnt_d = ram_cnt_q + (ADDR_W+1)'(1);
            end
            ACC_RD: begin
                ram_ce    = 1'b1;
                ram_ad    = rd_ptr_q;
                rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
                ram_cnt_d = ram_cnt_q - (ADDR_W+1)'(1);
            end
            default: ;
        endcase
        inflight_d = (w_acc == ACC_RD);
        prio_rd_d  = (w_wr_req && w_rd_req) ? !prio_rd_q : prio_rd_q;
        level_d    = level_q + (ADDR_W+1)'(w_wr_gnt) - (ADDR_W+1)'(w_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            level_q    <= '0;
            inflight_q <= 1'b0;
            prio_rd_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            level_q    <= level_d;
            inflight_q <= inflight_d;
            prio_rd_q  <= prio_rd_d;
        end
    end

    sp_fifo_obuf #(
        .DATA_W (DATA_W)
    ) u_obuf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inflight_q),
        .in_data   (ram_dout),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (w_obuf_cnt)
    );

    assign level     = level_q;
    assign ram_oce   = 1'b1;
    assign ram_reset = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_sp_fifo_ctrl.sv
`default_nettype none
// ============================================================
// tb_sp_fifo_ctrl : directed and random checks of sp_fifo_ctrl
// Rev 1.0
// ============================================================
module tb_sp_fifo_ctrl;

    localparam int DW = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [AW:0]   level;
    logic          ram_ce, ram_oce, ram_wre, ram_reset;
    logic [AW-1:0] ram_ad;
    logic [DW-1:0] ram_din, ram_dout;
    logic [DW-1:0] ram_mem [1 << AW];

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] sb [$];
    int            mlevel, acc_cnt, con_cnt;
    logic          last_ce, last_wre, last_ir;

    typedef struct packed {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [AW:0]   e_lvl;
        logic          e_ir;
        logic          e_ce;
        logic          e_wre;
    } vec_t;
    vec_t vt [13];

    always #5 clk = ~clk;

    sp_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
        .ram_ce    (ram_ce),
        .ram_oce   (ram_oce),
        .ram_wre   (ram_wre),
        .ram_reset (ram_reset),
        .ram_ad    (ram_ad),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Single-port RAM, read data one cycle after the access
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) ram_mem[ram_ad] <= ram_din;
            else         ram_dout <= ram_mem[ram_ad];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [DW-1:0] d, input logic o,
                                input logic ov, input logic [DW-1:0] od, input int lvl,
                                input logic ir, input logic ce, input logic wre);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = o;
        v.e_ov = ov; v.e_od = od; v.e_lvl = (AW+1)'(lvl);
        v.e_ir = ir; v.e_ce = ce; v.e_wre = wre;
        return v;
    endfunction

    // One cycle: drive at negedge, sample, update model, advance to next negedge
    task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy);
        logic          acc, con;
        logic [DW-1:0] exp;
        in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        acc = iv && in_ready;
        con = out_valid && ordy;
        last_ce = ram_ce; last_wre = ram_wre; last_ir = in_ready;
        check("level", 64'(level), 64'(mlevel));
        if (con) begin
            if (sb.size() == 0) begin
                check("pop_empty", 64'(out_valid), 64'd0);
            end else begin
                exp = sb.pop_front();
                check("data", 64'(out_data), 64'(exp));
            end
            con_cnt++;
        end
        if (acc) begin
            sb.push_back(d);
            acc_cnt++;
        end
        mlevel += int'(acc) - int'(con);
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete(); mlevel = 0; acc_cnt = 0; con_cnt = 0;
    endtask

    initial begin
        int   viol;
        logic prev_wre;

        vt[0]  = mk(1, 16'h0001, 1,  0, 16'h0000, 0, 1, 1, 1);
        vt[1]  = mk(0, 16'h0000, 1,  0, 16'h0000, 1, 1, 1, 0);
        vt[2]  = mk(0, 16'h0000, 1,  0, 16'h0000, 1, 1, 0, 0);
        vt[3]  = mk(0, 16'h0000, 1,  1, 16'h0001, 1, 1, 0, 0);
        vt[4]  = mk(1, 16'h0002, 1,  0, 16'h0000, 0, 1, 1, 1);
        vt[5]  = mk(1, 16'h0003, 1,  0, 16'h0000, 1, 1, 1, 1);
        vt[6]  = mk(1, 16'h0004, 1,  0, 16'h0000, 2, 0, 1, 0);
        vt[7]  = mk(1, 16'h0004, 1,  0, 16'h0000, 2, 1, 1, 1);
        vt[8]  = mk(0, 16'h0000, 1,  1, 16'h0002, 3, 0, 1, 0);
        vt[9]  = mk(0, 16'h0000, 1,  0, 16'h0000, 2, 0, 1, 0);
        vt[10] = mk(0, 16'h0000, 1,  1, 16'h0003, 2, 1, 0, 0);
        vt[11] = mk(0, 16'h0000, 1,  1, 16'h0004, 1, 1, 0, 0);
        vt[12] = mk(0, 16'h0000, 1,  0, 16'h0000, 0, 1, 0, 0);

        // Outputs held quiet during reset even with inputs active
        in_valid = 1'b1; in_data = 16'hFFFF; out_ready = 1'b1; reset = 1'b1;
        @(negedge clk);
        check("reset_outs",
              64'({out_valid, in_ready, ram_ce, ram_wre, ram_ad, ram_din, out_data, level, ram_oce, ram_reset}),
              64'({1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0, 16'h0, 11'h0, 1'b1, 1'b0}));
        in_valid = 1'b0;
        reset = 1'b0;
        sb.delete(); mlevel = 0; acc_cnt = 0; con_cnt = 0;

        // Latency and ordering vectors
        for (int i = 0; i < 13; i++) begin
            in_valid = vt[i].iv; in_data = vt[i].d; out_ready = vt[i].ordy;
            #1;
            check($sformatf("vec%0d", i),
                  64'({out_valid, (out_valid ? out_data : 16'h0), level, in_ready, ram_ce, ram_wre}),
                  64'({vt[i].e_ov, vt[i].e_od, vt[i].e_lvl, vt[i].e_ir, vt[i].e_ce, vt[i].e_wre}));
            @(negedge clk);
        end

        // Fill to capacity with the reader stalled, then drain across the wrap
        do_reset();
        for (int i = 0; i < 4000 && acc_cnt < 1026; i++) cyc(1'b1, 16'(acc_cnt + 32'h100), 1'b0);
        check("full_accepted", 64'(acc_cnt), 64'd1026);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 16'hDEAD, 1'b0);
            check("full_in_ready", 64'(last_ir), 64'd0);
        end
        check("full_level", 64'(level), 64'd1026);
        check("full_out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 3000 && con_cnt < acc_cnt; i++) cyc(1'b0, 16'h0, 1'b1);
        check("full_drained", 64'(con_cnt), 64'd1026);

        // Continuous streaming on both sides: accesses alternate W/R
        do_reset();
        viol = 0; prev_wre = 1'b0;
        for (int i = 0; i < 8000 && acc_cnt < 3000; i++) begin
            cyc(1'b1, 16'(acc_cnt * 7 + 3), 1'b1);
            if (acc_cnt >= 4 && acc_cnt < 2990 && (!last_ce || last_wre == prev_wre)) viol++;
            prev_wre = last_wre;
        end
        for (int i = 0; i < 100 && con_cnt < acc_cnt; i++) cyc(1'b0, 16'h0, 1'b1);
        check("stream_accepted", 64'(acc_cnt), 64'd3000);
        check("stream_consumed", 64'(con_cnt), 64'd3000);
        check("stream_alternate", 64'(viol), 64'd0);

        // Empty FIFO with an eager reader
        cyc(1'b0, 16'h0, 1'b1);
        check("empty_idle", 64'({out_valid, last_ce, level}), 64'd0);

        // Reset mid-operation with a read in flight
        do_reset();
        for (int i = 0; i < 2000 && acc_cnt < 501; i++) cyc(1'b1, 16'(acc_cnt + 32'h2000), 1'b0);
        cyc(1'b0, 16'h0, 1'b1);
        check("inflight_read", 64'({last_ce, last_wre}), 64'h2);
        check("pre_reset_level", 64'(level), 64'd500);
        out_ready = 1'b0; reset = 1'b1;
        #1;
        check("async_clear", 64'({level, out_valid, in_ready, ram_ce}), 64'd0);
        @(negedge clk);
        check("held_clear", 64'({level, out_valid, out_data}), 64'd0);
        reset = 1'b0;
        sb.delete(); mlevel = 0; acc_cnt = 0; con_cnt = 0;
        cyc(1'b1, 16'hBEEF, 1'b1);
        for (int i = 0; i < 20 && con_cnt < 1; i++) cyc(1'b0, 16'h0, 1'b1);
        check("beef_out", 64'(con_cnt), 64'd1);

        // Random 30% duty on both sides
        do_reset();
        for (int i = 0; i < 10000; i++)
            cyc($urandom_range(0, 9) < 3, 16'($urandom), $urandom_range(0, 9) < 3);
        for (int i = 0; i < 3000 && con_cnt < acc_cnt; i++) cyc(1'b0, 16'h0, 1'b1);
        check("rand_balance", 64'(con_cnt), 64'(acc_cnt));
        check("rand_level", 64'(level), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
